// File: rtl/team_08_gpio_pkg.sv
// Shared definitions for the team_08 Wishbone GPIO controller:
// register offsets, handshake FSM states and control bit positions.
package team_08_gpio_pkg;

    localparam logic [5:0] OFF_OUT_L  = 6'h00;
    localparam logic [5:0] OFF_OUT_H  = 6'h04;
    localparam logic [5:0] OFF_OEB_L  = 6'h08;
    localparam logic [5:0] OFF_OEB_H  = 6'h0C;
    localparam logic [5:0] OFF_IN_L   = 6'h10;
    localparam logic [5:0] OFF_IN_H   = 6'h14;
    localparam logic [5:0] OFF_REN_L  = 6'h18;
    localparam logic [5:0] OFF_REN_H  = 6'h1C;
    localparam logic [5:0] OFF_FEN_L  = 6'h20;
    localparam logic [5:0] OFF_FEN_H  = 6'h24;
    localparam logic [5:0] OFF_STAT_L = 6'h28;
    localparam logic [5:0] OFF_STAT_H = 6'h2C;
    localparam logic [5:0] OFF_IRQ_EN = 6'h30;

    // IRQ_EN enable bit; STAT high register starts at lane 32.
    localparam int IRQ_EN_BIT  = 0;
    localparam int STAT_HI_LSB = 32;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

endpackage

// File: rtl/team_08_gpio_sync_edge.sv
// Two-flop pad synchroniser plus a history flop, per lane.
// Ports: clk_i, nrst (sync, active low), pad (async in), sync/rise/fall out.
module team_08_gpio_sync_edge #(
    parameter int W = 34
) (
    input  logic         clk_i,
    input  logic         nrst,
    input  logic [W-1:0] pad,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta;
    logic [W-1:0] prev;

    always_ff @(posedge clk_i) begin
        if (!nrst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= pad;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/team_08_wb_gpio_ctrl.sv
// Wishbone classic GPIO controller: output data, active-low OE, synced inputs, edge IRQ.
// Ports: clk_i/nrst, wishbone slave (adr/dat/sel/we/cyc/stb/ack), gpio_in/out/oeb, irq_o.
module team_08_wb_gpio_ctrl
    import team_08_gpio_pkg::*;
#(
    parameter int               NGPIO     = 34,
    parameter logic [31:0]      BASE_ADDR = 32'h3000_0000,
    parameter logic [NGPIO-1:0] OEB_RST   = '1
) (
    input  logic             clk_i,
    input  logic             nrst,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    input  logic [3:0]       sel_i,
    input  logic             we_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    output logic             ack_o,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_oeb,
    output logic             irq_o
);

    state_t state;
    state_t state_nx;

    logic             hit;
    logic             acc;
    logic             wr;
    logic [5:0]       off;
    logic [2:0]       grp;
    logic [31:0]      bm;
    logic [31:0]      rdata;
    logic [NGPIO-1:0] wmask;
    logic [NGPIO-1:0] wdata;
    logic [NGPIO-1:0] m_out;
    logic [NGPIO-1:0] m_oeb;
    logic [NGPIO-1:0] m_ren;
    logic [NGPIO-1:0] m_fen;
    logic [NGPIO-1:0] m_stat;
    logic [NGPIO-1:0] rise_en;
    logic [NGPIO-1:0] fall_en;
    logic [NGPIO-1:0] stat;
    logic [NGPIO-1:0] sync_v;
    logic [NGPIO-1:0] rise_v;
    logic [NGPIO-1:0] fall_v;
    logic [NGPIO-1:0] set_v;
    logic             irq_en;
    logic [1:0]       unused_adr;

    assign unused_adr = adr_i[1:0];

    team_08_gpio_sync_edge #(
        .W(NGPIO)
    ) u_sync (
        .clk_i(clk_i),
        .nrst (nrst),
        .pad  (gpio_in),
        .sync (sync_v),
        .rise (rise_v),
        .fall (fall_v)
    );

    assign hit = cyc_i & stb_i & (adr_i[31:6] == BASE_ADDR[31:6]);
    assign acc = (state == IDLE) & hit;
    assign wr  = acc & we_i;
    assign off = {adr_i[5:2], 2'b00};
    assign grp = off[5:3];

    assign bm = {{8{sel_i[3]}}, {8{sel_i[2]}},
                 {8{sel_i[1]}}, {8{sel_i[0]}}};

    // Low/high word of a 64-bit lane space, truncated to NGPIO lanes.
    assign wmask = off[2] ? NGPIO'({bm, 32'h0})
                          : NGPIO'({32'h0, bm});
    assign wdata = NGPIO'({dat_i, dat_i});

    assign m_out  = (wr && grp == OFF_OUT_L[5:3])  ? wmask : '0;
    assign m_oeb  = (wr && grp == OFF_OEB_L[5:3])  ? wmask : '0;
    assign m_ren  = (wr && grp == OFF_REN_L[5:3])  ? wmask : '0;
    assign m_fen  = (wr && grp == OFF_FEN_L[5:3])  ? wmask : '0;
    assign m_stat = (wr && grp == OFF_STAT_L[5:3]) ? wmask : '0;

    assign set_v = (rise_v & rise_en) | (fall_v & fall_en);

    function automatic logic [NGPIO-1:0] merge(
        input logic [NGPIO-1:0] old,
        input logic [NGPIO-1:0] m,
        input logic [NGPIO-1:0] d
    );
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] rd_half(
        input logic [NGPIO-1:0] v,
        input logic             hi
    );
        logic [63:0] w;
        w = 64'(v);
        return hi ? w[63:32] : w[31:0];
    endfunction

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (grp == OFF_OUT_L[5:3]):  rdata = rd_half(gpio_out, off[2]);
            (grp == OFF_OEB_L[5:3]):  rdata = rd_half(gpio_oeb, off[2]);
            (grp == OFF_IN_L[5:3]):   rdata = rd_half(sync_v, off[2]);
            (grp == OFF_REN_L[5:3]):  rdata = rd_half(rise_en, off[2]);
            (grp == OFF_FEN_L[5:3]):  rdata = rd_half(fall_en, off[2]);
            (grp == OFF_STAT_L[5:3]): rdata = rd_half(stat, off[2]);
            (off == OFF_IRQ_EN):      rdata = 32'(irq_en);
            default:                  rdata = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (hit) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ack_o = (state == ACK);

    always_ff @(posedge clk_i) begin
        if (!nrst) begin
            state    <= IDLE;
            dat_o    <= '0;
            gpio_out <= '0;
            gpio_oeb <= OEB_RST;
            rise_en  <= '0;
            fall_en  <= '0;
            stat     <= '0;
            irq_en   <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            gpio_out <= merge(gpio_out, m_out, wdata);
            gpio_oeb <= merge(gpio_oeb, m_oeb, wdata);
            rise_en  <= merge(rise_en, m_ren, wdata);
            fall_en  <= merge(fall_en, m_fen, wdata);
            // New edges win over a same-cycle W1C clear.
            stat     <= (stat & ~(m_stat & wdata)) | set_v;
            irq_o    <= irq_en & (|stat);
            if (wr && off == OFF_IRQ_EN && sel_i[0])
                irq_en <= dat_i[IRQ_EN_BIT];
            if (acc && !we_i)
                dat_o <= rdata;
        end
    end

endmodule

// File: tb/tb_team_08_wb_gpio_ctrl.sv
// Self-checking bench for team_08_wb_gpio_ctrl: directed scenarios
// plus random bus traffic against a register-map reference model.
module tb_team_08_wb_gpio_ctrl;

    localparam int          NG    = 34;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [63:0] LMASK = 64'h3_FFFF_FFFF;

    logic          clk;
    logic          nrst;
    logic [31:0]   adr;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          ack;
    logic [NG-1:0] gpio_in;
    logic [NG-1:0] gpio_out;
    logic [NG-1:0] gpio_oeb;
    logic          irq;

    int n_chk = 0;
    int n_err = 0;
    bit mon_on = 0;

    team_08_wb_gpio_ctrl dut (
        .clk_i   (clk),
        .nrst    (nrst),
        .adr_i   (adr),
        .dat_i   (dat_w),
        .dat_o   (dat_r),
        .sel_i   (sel),
        .we_i    (we),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .ack_o   (ack),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oeb(gpio_oeb),
        .irq_o   (irq)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pad history, register file, one-outstanding bus.
    logic [63:0] m_out, m_oeb, m_ren, m_fen, m_stat;
    logic [63:0] h0, h1, h2;
    logic [31:0] m_rd;
    bit          m_ack, m_irq, m_irqen;

    function automatic logic [31:0] m_read(input logic [5:0] o);
        logic [63:0] v;
        v = 64'h0;
        case (o[5:3])
            3'd0: v = m_out;
            3'd1: v = m_oeb;
            3'd2: v = h1;
            3'd3: v = m_ren;
            3'd4: v = m_fen;
            3'd5: v = m_stat;
            3'd6: v = (o == 6'h30) ? 64'(m_irqen) : 64'h0;
            default: v = 64'h0;
        endcase
        if (o[5:3] == 3'd6) return v[31:0];
        return o[2] ? v[63:32] : v[31:0];
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] setv, clr, wm, wd;
        logic [31:0] wm32;
        logic [5:0]  o;
        bit          irq_n;
        if (!nrst) begin
            m_out = 0; m_oeb = LMASK; m_ren = 0; m_fen = 0;
            m_stat = 0; h0 = 0; h1 = 0; h2 = 0;
            m_ack = 0; m_irq = 0; m_irqen = 0;
        end else begin
            // h1 is what the synchroniser shows now, h2 the sample before it.
            setv  = (m_ren & h1 & ~h2) | (m_fen & ~h1 & h2);
            clr   = 0;
            irq_n = m_irqen && (m_stat != 0);
            if (m_ack) begin
                m_ack = 0;
            end else if (cyc && stb && adr[31:6] == BASE[31:6]) begin
                m_ack = 1;
                o     = {adr[5:2], 2'b00};
                m_rd  = m_read(o);
                if (we) begin
                    wm32 = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                    wm   = o[2] ? {wm32, 32'h0} : {32'h0, wm32};
                    wm   = wm & LMASK;
                    wd   = {dat_w, dat_w};
                    case (o[5:3])
                        3'd0: m_out = (m_out & ~wm) | (wd & wm);
                        3'd1: m_oeb = (m_oeb & ~wm) | (wd & wm);
                        3'd3: m_ren = (m_ren & ~wm) | (wd & wm);
                        3'd4: m_fen = (m_fen & ~wm) | (wd & wm);
                        3'd5: clr = wd & wm;
                        3'd6: if (o == 6'h30 && sel[0]) m_irqen = dat_w[0];
                        default: ;
                    endcase
                end
            end
            m_stat = ((m_stat & ~clr) | setv) & LMASK;
            m_irq  = irq_n;
            h2 = h1;
            h1 = h0;
            h0 = 64'(gpio_in);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("ack", 64'(ack), 64'(m_ack));
            chk("gpio_out", 64'(gpio_out), m_out);
            chk("gpio_oeb", 64'(gpio_oeb), m_oeb);
            chk("irq", 64'(irq), 64'(m_irq));
        end
    end

    // Starts and ends on a falling edge; leaves one idle cycle after ack.
    task automatic wb_rw(input bit w, input logic [5:0] o,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd);
        int n;
        cyc = 1; stb = 1; we = w;
        adr = BASE | 32'(o); dat_w = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        chk("ack_lat", 64'(n), 64'd1);
        rd = dat_r;
        if (!w) chk("rdata", 64'(dat_r), 64'(m_rd));
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        chk("ack_drop", 64'(ack), 64'd0);
        if (!w) chk("rd_hold", 64'(dat_r), 64'(rd));
    endtask

    logic [31:0] rd;
    logic [63:0] r64;

    initial begin
        nrst = 0; adr = 0; dat_w = 0; sel = 0;
        we = 0; cyc = 0; stb = 0; gpio_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        chk("rst_out", 64'(gpio_out), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        nrst = 1;
        mon_on = 1;
        @(negedge clk);

        // Byte-lane write
        wb_rw(1, 6'h00, 32'hA5A5_5A5A, 4'b0011, rd);
        chk("out_pad", 64'(gpio_out), 64'h5A5A);
        wb_rw(0, 6'h00, 32'h0, 4'hF, rd);
        chk("out_l_rd", 64'(rd), 64'h5A5A);
        wb_rw(1, 6'h04, 32'hFFFF_FFFF, 4'hF, rd);
        wb_rw(0, 6'h04, 32'h0, 4'hF, rd);
        chk("out_h_rd", 64'(rd), 64'h3);

        // Rising edge interrupt on lane 3
        wb_rw(1, 6'h18, 32'h8, 4'hF, rd);
        wb_rw(1, 6'h30, 32'h1, 4'hF, rd);
        gpio_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_pre", 64'(irq), 64'h0);
        @(negedge clk);
        chk("irq_set", 64'(irq), 64'h1);
        wb_rw(0, 6'h28, 32'h0, 4'hF, rd);
        chk("stat_rd", 64'(rd), 64'h8);
        wb_rw(1, 6'h28, 32'h8, 4'hF, rd);
        chk("irq_clr", 64'(irq), 64'h0);

        // Clear colliding with a new edge: set wins
        gpio_in[3] = 1'b0;
        repeat (4) @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (2) @(negedge clk);
        wb_rw(1, 6'h28, 32'h8, 4'hF, rd);
        chk("coll_irq", 64'(irq), 64'h1);
        wb_rw(0, 6'h28, 32'h0, 4'hF, rd);
        chk("coll_stat", 64'(rd), 64'h8);
        wb_rw(1, 6'h28, 32'h8, 4'hF, rd);

        // Back-to-back strobes acked on alternate cycles
        cyc = 1; stb = 1; we = 0; adr = BASE; sel = 4'hF;
        chk("bb0", 64'(ack), 64'h0);
        @(negedge clk);
        chk("bb1", 64'(ack), 64'h1);
        chk("bb1_rd", 64'(dat_r), 64'(m_rd));
        @(negedge clk);
        chk("bb2", 64'(ack), 64'h0);
        @(negedge clk);
        chk("bb3", 64'(ack), 64'h1);
        cyc = 0; stb = 0;
        @(negedge clk);
        wb_rw(0, 6'h3C, 32'h0, 4'hF, rd);
        chk("unmapped", 64'(rd), 64'h0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r64 = {$urandom, $urandom};
                gpio_in = r64[NG-1:0];
            end
            r64 = {$urandom, $urandom};
            wb_rw(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15) * 4),
                  r64[31:0], r64[35:32], rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during an OEB write
        cyc = 1; stb = 1; we = 1; adr = BASE | 32'h08;
        dat_w = 32'h0; sel = 4'hF;
        #2 nrst = 0;
        @(negedge clk);
        chk("rst_mid_ack", 64'(ack), 64'h0);
        chk("rst_mid_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        cyc = 0; stb = 0; we = 0;
        nrst = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        chk("post_rst_out", 64'(gpio_out), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
